// File: rtl/axi_wr_arbiter_if.sv
// AXI write-channel bundle (AW, W, B) shared by the arbiter's master-facing and slave-facing ports.
interface axi_wr_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  // Side that issues writes
  modport mst (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  // Side that accepts writes
  modport slv (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-master round-robin AXI write arbiter: one whole AW/W/B transaction owns the slave port at a time.
module axi_wr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic               clk,
  input  logic               resetn,
  axi_wr_arbiter_if.slv      m0,
  axi_wr_arbiter_if.slv      m1,
  axi_wr_arbiter_if.mst      s,
  output logic               grant,
  output logic               busy,
  output logic               err_wlast
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state;
  logic       last_grant;
  logic [7:0] beat;
  logic [7:0] awlen_q;

  logic [ID_WIDTH-1:0]   sel_awid;
  logic [ADDR_WIDTH-1:0] sel_awaddr;
  logic [7:0]            sel_awlen;
  logic [2:0]            sel_awsize;
  logic [1:0]            sel_awburst;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  sel_wlast;
  logic                  sel_wvalid;
  logic                  sel_bready;
  logic                  nxt_grant;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  len_err;

  // Granted master's channels
  assign sel_awid    = grant ? m1.awid    : m0.awid;
  assign sel_awaddr  = grant ? m1.awaddr  : m0.awaddr;
  assign sel_awlen   = grant ? m1.awlen   : m0.awlen;
  assign sel_awsize  = grant ? m1.awsize  : m0.awsize;
  assign sel_awburst = grant ? m1.awburst : m0.awburst;
  assign sel_wdata   = grant ? m1.wdata   : m0.wdata;
  assign sel_wstrb   = grant ? m1.wstrb   : m0.wstrb;
  assign sel_wlast   = grant ? m1.wlast   : m0.wlast;
  assign sel_wvalid  = grant ? m1.wvalid  : m0.wvalid;
  assign sel_bready  = grant ? m1.bready  : m0.bready;

  // On a tie the master that did not win last time gets the port
  assign nxt_grant = (m0.awvalid && m1.awvalid) ? ~last_grant : m1.awvalid;
  assign aw_hs     = (state == ADDR) && s.awready;
  assign w_hs      = (state == DATA) && sel_wvalid && s.wready;
  assign b_hs      = (state == RESP) && s.bvalid && sel_bready;
  assign len_err   = sel_wlast ? (beat != awlen_q) : (beat == awlen_q);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat       <= 8'd0;
      awlen_q    <= 8'd0;
      err_wlast  <= 1'b0;
    end else begin
      err_wlast <= 1'b0;
      case (state)
        IDLE: begin
          if (m0.awvalid || m1.awvalid) begin
            grant      <= nxt_grant;
            last_grant <= nxt_grant;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            awlen_q <= sel_awlen;
            beat    <= 8'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          // Beat count only flags length errors; wlast alone ends the burst
          if (w_hs) begin
            beat      <= 8'(beat + 8'd1);
            err_wlast <= len_err;
            if (sel_wlast) state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s.awid     = '0;
    s.awaddr   = '0;
    s.awlen    = '0;
    s.awsize   = '0;
    s.awburst  = '0;
    s.awvalid  = 1'b0;
    s.wdata    = '0;
    s.wstrb    = '0;
    s.wlast    = 1'b0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bid     = '0;
    m0.bresp   = '0;
    m0.bvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bid     = '0;
    m1.bresp   = '0;
    m1.bvalid  = 1'b0;
    case (state)
      ADDR: begin
        s.awid     = sel_awid;
        s.awaddr   = sel_awaddr;
        s.awlen    = sel_awlen;
        s.awsize   = sel_awsize;
        s.awburst  = sel_awburst;
        s.awvalid  = 1'b1;
        m0.awready = ~grant & s.awready;
        m1.awready = grant & s.awready;
      end
      DATA: begin
        s.wdata   = sel_wdata;
        s.wstrb   = sel_wstrb;
        s.wlast   = sel_wlast;
        s.wvalid  = sel_wvalid;
        m0.wready = ~grant & s.wready;
        m1.wready = grant & s.wready;
      end
      RESP: begin
        s.bready = sel_bready;
        if (grant) begin
          m1.bid    = s.bid;
          m1.bresp  = s.bresp;
          m1.bvalid = s.bvalid;
        end else begin
          m0.bid    = s.bid;
          m0.bresp  = s.bresp;
          m0.bvalid = s.bvalid;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed, cycle-exact bench for the two-master AXI write arbiter.
module tb_axi_wr_arbiter;
  logic clk;
  logic resetn;
  logic grant;
  logic busy;
  logic err_wlast;
  int   total;
  int   bad;

  axi_wr_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) m0_if ();
  axi_wr_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) m1_if ();
  axi_wr_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) s_if ();

  axi_wr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant(grant), .busy(busy), .err_wlast(err_wlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task zero_inputs();
    m0_if.awid = '0; m0_if.awaddr = '0; m0_if.awlen = '0; m0_if.awsize = '0; m0_if.awburst = '0;
    m0_if.awvalid = 0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wlast = 0; m0_if.wvalid = 0; m0_if.bready = 0;
    m1_if.awid = '0; m1_if.awaddr = '0; m1_if.awlen = '0; m1_if.awsize = '0; m1_if.awburst = '0;
    m1_if.awvalid = 0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wlast = 0; m1_if.wvalid = 0; m1_if.bready = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.bid = '0; s_if.bresp = '0; s_if.bvalid = 0;
  endtask

  task apply_reset();
    resetn = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task test_reset();
    resetn = 1'b0;
    zero_inputs();
    m0_if.awvalid = 1; m1_if.wvalid = 1; s_if.bvalid = 1; s_if.awready = 1; s_if.wready = 1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (grant !== 1'b0) begin bad++; $display("FAIL rst_grant got=%0b exp=0", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (err_wlast !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err_wlast); end
    total++; if ({s_if.awvalid, s_if.wvalid, s_if.bready} !== 3'b000) begin bad++; $display("FAIL rst_s_valid got=%b exp=000", {s_if.awvalid, s_if.wvalid, s_if.bready}); end
    total++; if ({m0_if.awready, m0_if.wready, m0_if.bvalid, m1_if.awready, m1_if.wready, m1_if.bvalid} !== 6'b0) begin bad++; $display("FAIL rst_m_hs got=%b exp=000000", {m0_if.awready, m0_if.wready, m0_if.bvalid, m1_if.awready, m1_if.wready, m1_if.bvalid}); end
    zero_inputs();
    resetn = 1'b1;
  endtask

  task test_single_m0();
    apply_reset();
    m0_if.awvalid = 1; m0_if.awaddr = 32'h100; m0_if.awlen = 8'd3; m0_if.awid = 4'h5;
    m0_if.awsize = 3'd2; m0_if.awburst = 2'd1; m0_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1;
    #1;
    total++; if ({busy, s_if.awvalid} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b exp=00", {busy, s_if.awvalid}); end
    @(negedge clk);
    // W offered early must not leak through while in ADDR
    m0_if.wvalid = 1; m0_if.wdata = 32'hA0; m0_if.wstrb = 4'hF;
    #1;
    total++; if (s_if.awvalid !== 1'b1) begin bad++; $display("FAIL single_awvalid got=%0b exp=1", s_if.awvalid); end
    total++; if (s_if.awaddr !== 32'h100 || s_if.awlen !== 8'd3 || s_if.awid !== 4'h5) begin bad++; $display("FAIL single_aw_payload got=%h/%h/%h exp=100/03/5", s_if.awaddr, s_if.awlen, s_if.awid); end
    total++; if ({m0_if.awready, m1_if.awready, grant} !== 3'b100) begin bad++; $display("FAIL single_awready got=%b exp=100", {m0_if.awready, m1_if.awready, grant}); end
    total++; if ({s_if.wvalid, m0_if.wready} !== 2'b00) begin bad++; $display("FAIL single_early_w got=%b exp=00", {s_if.wvalid, m0_if.wready}); end
    @(negedge clk);
    m0_if.awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      m0_if.wdata = 32'hA0 + i; m0_if.wlast = (i == 3);
      #1;
      total++; if (s_if.wvalid !== 1'b1 || s_if.wdata !== 32'hA0 + i || s_if.wlast !== (i == 3)) begin bad++; $display("FAIL single_w%0d got=%b/%h/%b", i, s_if.wvalid, s_if.wdata, s_if.wlast); end
      total++; if ({m0_if.wready, m1_if.wready, err_wlast} !== 3'b100) begin bad++; $display("FAIL single_wready%0d got=%b exp=100", i, {m0_if.wready, m1_if.wready, err_wlast}); end
      @(negedge clk);
    end
    m0_if.wvalid = 0; m0_if.wlast = 0;
    s_if.bvalid = 1; s_if.bid = 4'h5; s_if.bresp = 2'd0;
    #1;
    total++; if ({m0_if.bvalid, m1_if.bvalid, s_if.bready, busy, err_wlast} !== 5'b10110) begin bad++; $display("FAIL single_b got=%b exp=10110", {m0_if.bvalid, m1_if.bvalid, s_if.bready, busy, err_wlast}); end
    total++; if (m0_if.bid !== 4'h5 || s_if.awvalid !== 1'b0) begin bad++; $display("FAIL single_bid got=%h/%b exp=5/0", m0_if.bid, s_if.awvalid); end
    @(negedge clk);
    s_if.bvalid = 0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_done got=%0b exp=0", busy); end
  endtask

  task test_round_robin();
    int gs[4];
    int at[4];
    int ngr;
    apply_reset();
    m0_if.awvalid = 1; m1_if.awvalid = 1; m0_if.wvalid = 1; m1_if.wvalid = 1;
    m0_if.wlast = 1; m1_if.wlast = 1; m0_if.bready = 1; m1_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1; s_if.bvalid = 1;
    ngr = 0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      #1;
      if (s_if.awvalid === 1'b1) begin
        gs[ngr] = int'(grant); at[ngr] = c; ngr++;
        total++; if ((m0_if.awready & m1_if.awready) !== 1'b0) begin bad++; $display("FAIL rr_both_awready c=%0d", c); end
      end
      @(negedge clk);
    end
    total++; if (ngr !== 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", ngr); end
    for (int i = 0; i < ngr; i++) begin
      total++; if (gs[i] !== i % 2) begin bad++; $display("FAIL rr_order%0d got=%0d exp=%0d", i, gs[i], i % 2); end
      total++; if (at[i] !== 1 + 4 * i) begin bad++; $display("FAIL rr_cycle%0d got=%0d exp=%0d", i, at[i], 1 + 4 * i); end
    end
    zero_inputs();
  endtask

  task test_wready_toggle();
    apply_reset();
    m1_if.awvalid = 1; m1_if.awlen = 8'd1; m1_if.awid = 4'h3; m1_if.bready = 1;
    s_if.awready = 1;
    @(negedge clk);
    #1;
    total++; if ({grant, s_if.awvalid, m1_if.awready, m0_if.awready} !== 4'b1110) begin bad++; $display("FAIL tog_aw got=%b exp=1110", {grant, s_if.awvalid, m1_if.awready, m0_if.awready}); end
    @(negedge clk);
    m1_if.awvalid = 0; m1_if.wvalid = 1; m1_if.wdata = 32'h11; m1_if.wlast = 0; s_if.wready = 1;
    #1;
    total++; if ({m1_if.wready, m0_if.wready} !== 2'b10) begin bad++; $display("FAIL tog_ready1 got=%b exp=10", {m1_if.wready, m0_if.wready}); end
    @(negedge clk);
    m1_if.wdata = 32'h22; m1_if.wlast = 1; s_if.wready = 0;
    #1;
    total++; if ({m1_if.wready, s_if.wvalid, err_wlast} !== 3'b010) begin bad++; $display("FAIL tog_ready0 got=%b exp=010", {m1_if.wready, s_if.wvalid, err_wlast}); end
    @(negedge clk);
    s_if.wready = 1;
    #1;
    total++; if ({m1_if.wready, s_if.wvalid, s_if.wlast} !== 3'b111 || s_if.wdata !== 32'h22) begin bad++; $display("FAIL tog_held got=%b/%h exp=111/22", {m1_if.wready, s_if.wvalid, s_if.wlast}, s_if.wdata); end
    @(negedge clk);
    m1_if.wvalid = 0; m1_if.wlast = 0;
    s_if.bvalid = 1; s_if.bid = 4'h3; s_if.bresp = 2'd2;
    #1;
    total++; if ({m1_if.bvalid, m0_if.bvalid, s_if.bready, err_wlast, s_if.wvalid} !== 5'b10100) begin bad++; $display("FAIL tog_resp got=%b exp=10100", {m1_if.bvalid, m0_if.bvalid, s_if.bready, err_wlast, s_if.wvalid}); end
    total++; if (m1_if.bresp !== 2'd2 || m1_if.bid !== 4'h3) begin bad++; $display("FAIL tog_bresp got=%0d/%h exp=2/3", m1_if.bresp, m1_if.bid); end
    @(negedge clk);
    s_if.bvalid = 0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tog_done got=%0b exp=0", busy); end
  endtask

  task test_len_err();
    // Early wlast: awlen=2, wlast on beat 1
    apply_reset();
    m0_if.awvalid = 1; m0_if.awlen = 8'd2; m0_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1;
    @(negedge clk);
    @(negedge clk);
    m0_if.awvalid = 0; m0_if.wvalid = 1; m0_if.wlast = 0;
    @(negedge clk);
    m0_if.wlast = 1;
    #1;
    total++; if (err_wlast !== 1'b0) begin bad++; $display("FAIL lenerr_early0 got=%0b exp=0", err_wlast); end
    @(negedge clk);
    m0_if.wvalid = 0; m0_if.wlast = 0;
    s_if.bvalid = 1; s_if.bid = 4'h7; s_if.bresp = 2'd2;
    #1;
    total++; if ({err_wlast, busy, s_if.wvalid, m0_if.bvalid} !== 4'b1101) begin bad++; $display("FAIL lenerr_early got=%b exp=1101", {err_wlast, busy, s_if.wvalid, m0_if.bvalid}); end
    total++; if (m0_if.bid !== 4'h7 || m0_if.bresp !== 2'd2) begin bad++; $display("FAIL lenerr_b got=%h/%0d exp=7/2", m0_if.bid, m0_if.bresp); end
    @(negedge clk);
    s_if.bvalid = 0;
    #1;
    total++; if ({err_wlast, busy} !== 2'b00) begin bad++; $display("FAIL lenerr_pulse got=%b exp=00", {err_wlast, busy}); end
    // Late wlast: awlen=0 but two beats, both flagged
    apply_reset();
    m0_if.awvalid = 1; m0_if.awlen = 8'd0; m0_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1;
    @(negedge clk);
    @(negedge clk);
    m0_if.awvalid = 0; m0_if.wvalid = 1; m0_if.wlast = 0;
    @(negedge clk);
    m0_if.wlast = 1;
    #1;
    total++; if ({err_wlast, s_if.wvalid} !== 2'b11) begin bad++; $display("FAIL lenerr_late0 got=%b exp=11", {err_wlast, s_if.wvalid}); end
    @(negedge clk);
    m0_if.wvalid = 0; m0_if.wlast = 0; s_if.bvalid = 1;
    #1;
    total++; if ({err_wlast, m0_if.bvalid} !== 2'b11) begin bad++; $display("FAIL lenerr_late1 got=%b exp=11", {err_wlast, m0_if.bvalid}); end
    @(negedge clk);
    s_if.bvalid = 0;
  endtask

  task test_reset_mid();
    apply_reset();
    m1_if.awvalid = 1; m1_if.awlen = 8'd3; m1_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1;
    @(negedge clk);
    @(negedge clk);
    m1_if.awvalid = 0; m1_if.wvalid = 1;
    #1;
    total++; if ({m1_if.wready, busy} !== 2'b11) begin bad++; $display("FAIL rmid_data got=%b exp=11", {m1_if.wready, busy}); end
    @(negedge clk);
    resetn = 1'b0; s_if.bvalid = 1;
    @(negedge clk);
    #1;
    total++; if ({busy, grant, s_if.wvalid, m1_if.wready, m1_if.bvalid, s_if.bready} !== 6'b0) begin bad++; $display("FAIL rmid_clear got=%b exp=000000", {busy, grant, s_if.wvalid, m1_if.wready, m1_if.bvalid, s_if.bready}); end
    resetn = 1'b1; s_if.bvalid = 0; m1_if.wvalid = 0;
    m0_if.awvalid = 1; m1_if.awvalid = 1;
    @(negedge clk);
    #1;
    total++; if ({grant, s_if.awvalid, m0_if.awready} !== 3'b011) begin bad++; $display("FAIL rmid_tie got=%b exp=011", {grant, s_if.awvalid, m0_if.awready}); end
    zero_inputs();
  endtask

  task test_bready_stall();
    apply_reset();
    m0_if.awvalid = 1; m0_if.awlen = 8'd0;
    s_if.awready = 1; s_if.wready = 1;
    @(negedge clk);
    @(negedge clk);
    m0_if.awvalid = 0; m0_if.wvalid = 1; m0_if.wlast = 1;
    @(negedge clk);
    m0_if.wvalid = 0; m0_if.wlast = 0; s_if.bvalid = 1; s_if.bid = 4'h9;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({s_if.bready, busy, m0_if.bvalid} !== 3'b011) begin bad++; $display("FAIL stall%0d got=%b exp=011", i, {s_if.bready, busy, m0_if.bvalid}); end
      @(negedge clk);
    end
    m0_if.bready = 1;
    #1;
    total++; if ({s_if.bready, m0_if.bid} !== {1'b1, 4'h9}) begin bad++; $display("FAIL stall_release got=%b/%h exp=1/9", s_if.bready, m0_if.bid); end
    @(negedge clk);
    s_if.bvalid = 0; m0_if.bready = 0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_done got=%0b exp=0", busy); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetn = 1'b0;
    zero_inputs();
    test_reset();
    test_single_m0();
    test_round_robin();
    test_wready_toggle();
    test_len_err();
    test_reset_mid();
    test_bready_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-master, one-slave AXI write-path arbiter that shares a single `axi_interface` slave port between two requesters. Round-robin grants one complete write transaction (AW, W burst, B) at a time. It forwards the granted master's channels to the slave and holds the other master stalled. It sits between the masters and the slave's write channels; read channels are not touched.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width DATA_WIDTH/8
- ID_WIDTH, 4, transaction ID width, passed through unchanged
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- mN_awid / mN_awaddr / mN_awlen / mN_awsize / mN_awburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  master N (N=0,1) write address
- mN_awvalid  in  1; mN_awready  out  1  master N AW handshake
- mN_wdata / mN_wstrb / mN_wlast  in  DATA_WIDTH / DATA_WIDTH/8 / 1  master N write data
- mN_wvalid  in  1; mN_wready  out  1  master N W handshake
- mN_bid / mN_bresp  out  ID_WIDTH / 2  master N write response
- mN_bvalid  out  1; mN_bready  in  1  master N B handshake
- s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid  out  (widths as above)  to slave; s_awready  in  1
- s_wdata, s_wstrb, s_wlast, s_wvalid  out  (widths as above)  to slave; s_wready  in  1
- s_bid, s_bresp, s_bvalid  in  ID_WIDTH / 2 / 1  from slave; s_bready  out  1
- grant  out  1  index of currently/last granted master
- busy  out  1  high in any state other than IDLE
- err_wlast  out  1  one-cycle pulse on burst length mismatch

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Registered: state, grant, last_grant, beat (8-bit), awlen_q.
- IDLE: if exactly one mN_awvalid high, grant <= N. If both high, grant <= ~last_grant. Then go to ADDR, last_grant <= new grant. No request: stay.
- ADDR: s_aw* = granted master's aw* fields; s_awvalid = 1; m[grant]_awready = s_awready. On s_awvalid&s_awready: awlen_q <= awlen, beat <= 0, go to DATA.
- DATA: s_w* = granted master's w*; s_wvalid = m[grant]_wvalid; m[grant]_wready = s_wready. Each W handshake: beat <= beat+1 (8-bit, wraps). On handshake with wlast=1: go to RESP.
- Length check, evaluated on each W handshake:
  - err_wlast pulses next cycle if wlast=1 and beat != awlen_q.
  - err_wlast pulses next cycle if wlast=0 and beat == awlen_q.
  - Transition always follows wlast, never beat count.
- RESP: m[grant]_bid/bresp/bvalid = s_bid/s_bresp/s_bvalid; s_bready = m[grant]_bready. On s_bvalid&s_bready: go to IDLE.
- Non-granted master, and every master outside its active state: awready, wready, bvalid = 0; bid, bresp = 0.
- s_* payload outputs are 0 when their channel is not active.
- W data offered by a master before its AW is accepted is not forwarded; it waits for DATA.
- grant = grant register; busy = (state != IDLE).

## Timing
- Reset (resetn low at a clk edge):
  - state=IDLE, grant=0, last_grant=1 (m0 wins first tie), beat=0, err_wlast=0.
  - All valid/ready outputs are 0.
  - Reset mid-transaction abandons it; no B is generated.
- Arbitration latency: request seen in IDLE at edge k; s_awvalid high from cycle k+1.
- Handshake forwarding is combinational within the active state, so there is zero added latency per beat. A full-throughput burst moves one beat per cycle.
- Minimum transaction: 1 cycle IDLE + 1 ADDR + 1 DATA (awlen=0) + 1 RESP = 4 cycles. The next grant decision happens in the IDLE cycle after the B handshake.
- Only one outstanding write at a time; no ID remapping is needed because B routing uses grant.
- AXI rule relied on: masters hold awvalid/wvalid and payload stable until the handshake.

## Test plan
- m0 only, awaddr=0x100, awlen=3, 4 beats, slave always ready -> s_awvalid at cycle 1, 4 W beats on cycles 2-5, B to m0 only, m1_* ready/valid stay 0, err_wlast=0.
- m0 and m1 request in the same cycle after reset -> grant=0 first. After m0's B handshake, grant=1. Repeat both requests -> order alternates 0,1,0,1.
- m1 burst awlen=1, s_wready toggles 1,0,1 -> m1_wready mirrors s_wready, beat count ends at 2, transition to RESP only on the wlast handshake.
- m0 awlen=2 but wlast on 2nd beat -> err_wlast pulses one cycle, FSM enters RESP, B delivered with slave's bresp/bid.
- resetn low during DATA of an m1 burst -> next cycle all outputs 0, state IDLE. A subsequent simultaneous request grants m0.
- s_bvalid held while m0_bready=0 for 3 cycles -> s_bready=0, stays in RESP, busy=1. Completes on the cycle m0_bready=1.
